// File: rtl/add_matrix_seq.sv
// Sequential element-wise matrix add/subtract with ready/valid handshakes.
// Operands are registered on acceptance, then ROWS_PER_CYCLE rows are computed per
// cycle into the result register c. overflow is the sticky OR of per-element signed
// overflow for the current matrix.
// Optional build macro: ADD_MATRIX_SEQ_SAT_EN -- overflowing elements saturate instead
// of wrapping; the overflow flag behaves the same in both builds.
module add_matrix_seq #(
  parameter int unsigned BITS           = 16,
  parameter int unsigned N              = 3,
  parameter int unsigned M              = 2,
  parameter int unsigned ROWS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            mode,
  input  logic [BITS-1:0] a [N][M],
  input  logic [BITS-1:0] b [N][M],
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] c [N][M],
  output logic            overflow
);

  localparam int unsigned RW = (N > 1) ? $clog2(N) : 1;
  localparam logic [RW-1:0] LastRow = RW'(N - ROWS_PER_CYCLE);

  if ((N % ROWS_PER_CYCLE) != 0) begin : g_bad_rows
    $error("add_matrix_seq: N must be a multiple of ROWS_PER_CYCLE");
  end

`ifdef ADD_MATRIX_SEQ_SAT_EN
  localparam logic [BITS-1:0] MaxPos = {1'b0, {(BITS-1){1'b1}}};
  localparam logic [BITS-1:0] MinNeg = {1'b1, {(BITS-1){1'b0}}};
`endif

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [BITS-1:0] a_q [N][M];
  logic [BITS-1:0] a_d [N][M];
  logic [BITS-1:0] b_q [N][M];
  logic [BITS-1:0] b_d [N][M];
  logic [BITS-1:0] c_q [N][M];
  logic [BITS-1:0] c_d [N][M];
  logic            mode_q, mode_d;
  logic            ovf_q, ovf_d;
  logic [RW-1:0]   r_q, r_d;

  // Per-element scratch values used inside the row loop.
  logic [RW-1:0]   row_idx;
  logic [BITS-1:0] ea, eb, es;
  logic            eovf;

  // Next-state, datapath and handshake outputs.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    mode_d    = mode_q;
    ovf_d     = ovf_q;
    r_d       = r_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    row_idx   = '0;
    ea        = '0;
    eb        = '0;
    es        = '0;
    eovf      = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          ovf_d   = 1'b0;
          r_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int g = 0; g < int'(ROWS_PER_CYCLE); g++) begin
          for (int j = 0; j < int'(M); j++) begin
            row_idx = r_q + RW'(g);
            ea      = a_q[row_idx][j];
            eb      = b_q[row_idx][j];
            es      = mode_q ? (ea - eb) : (ea + eb);
            // Add overflows on equal operand signs, subtract on differing signs;
            // either way the result sign then disagrees with a.
            eovf    = ((ea[BITS-1] == eb[BITS-1]) ^ mode_q) && (es[BITS-1] != ea[BITS-1]);
`ifdef ADD_MATRIX_SEQ_SAT_EN
            // The overflow direction follows the sign of a in both modes.
            if (eovf) es = ea[BITS-1] ? MinNeg : MaxPos;
`endif
            c_d[row_idx][j] = es;
            ovf_d           = ovf_d | eovf;
          end
        end
        if (r_q == LastRow) begin
          r_d     = '0;
          state_d = StDone;
        end else begin
          r_d = r_q + RW'(ROWS_PER_CYCLE);
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      ovf_q   <= 1'b0;
      r_q     <= '0;
      for (int i = 0; i < int'(N); i++) begin
        for (int j = 0; j < int'(M); j++) begin
          a_q[i][j] <= '0;
          b_q[i][j] <= '0;
          c_q[i][j] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
      r_q     <= r_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
    end
  end

  assign c        = c_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_add_matrix_seq.sv
// Directed bench for add_matrix_seq: a default instance and a ROWS_PER_CYCLE=3
// instance share all inputs; both are checked against hand-computed vectors.
module tb_add_matrix_seq;
  localparam int BITS = 16;
  localparam int N    = 3;
  localparam int M    = 2;

`ifdef ADD_MATRIX_SEQ_SAT_EN
  localparam logic [15:0] E3 = 16'h7FFF;
  localparam logic [15:0] E4 = 16'h8000;
  localparam logic [15:0] E5 = 16'h8000;
`else
  localparam logic [15:0] E3 = 16'h8000;
  localparam logic [15:0] E4 = 16'h7FFF;
  localparam logic [15:0] E5 = 16'h7FFD;
`endif

  typedef logic [N*M-1:0][BITS-1:0] mat_t;
  typedef struct packed {
    logic mode;
    mat_t a;
    mat_t b;
    mat_t c;
    logic ovf;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, in_valid, mode, out_ready;
  logic [BITS-1:0] a [N][M];
  logic [BITS-1:0] b [N][M];
  logic            in_ready, out_valid, overflow;
  logic [BITS-1:0] c [N][M];
  logic            in_ready3, out_valid3, overflow3;
  logic [BITS-1:0] c3 [N][M];
  mat_t            c_flat, c3_flat;

  int checks = 0;
  int errors = 0;
  vec_t vecs [5];

  add_matrix_seq #(.BITS(BITS), .N(N), .M(M), .ROWS_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .c(c), .overflow(overflow)
  );

  add_matrix_seq #(.BITS(BITS), .N(N), .M(M), .ROWS_PER_CYCLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3), .mode(mode),
    .a(a), .b(b), .out_valid(out_valid3), .out_ready(out_ready), .c(c3),
    .overflow(overflow3)
  );

  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < M; j++) begin
        c_flat[i*M+j]  = c[i][j];
        c3_flat[i*M+j] = c3[i][j];
      end
    end
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input mat_t va, input mat_t vb, input logic vm);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < M; j++) begin
        a[i][j] = va[i*M+j];
        b[i][j] = vb[i*M+j];
      end
    end
    mode = vm;
  endtask

  // Called at the first falling edge after the accepting edge.
  task automatic wait_result(input string name, input mat_t ec, input logic eo);
    int lat, lat3;
    lat  = 0;
    lat3 = out_valid3 ? 0 : -1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid3 && lat3 < 0) lat3 = lat;
    end
    check({name, " latency"}, 96'(lat), 96'(3));
    check({name, " latency rpc3"}, 96'(lat3), 96'(1));
    check({name, " c"}, 96'(c_flat), 96'(ec));
    check({name, " overflow"}, 96'(overflow), 96'(eo));
    check({name, " c rpc3"}, 96'(c3_flat), 96'(ec));
    check({name, " overflow rpc3"}, 96'(overflow3), 96'(eo));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " out_valid drop"}, 96'({out_valid, out_valid3}), 96'(0));
  endtask

  task automatic run_vec(input vec_t v, input string name);
    @(negedge clk);
    drive(v.a, v.b, v.mode);
    in_valid = 1'b1;
    check({name, " in_ready"}, 96'({in_ready, in_ready3}), 96'(3));
    @(negedge clk);
    in_valid = 1'b0;
    // Scrambled inputs after acceptance must not reach c.
    drive(~v.a, ~v.b, ~v.mode);
    wait_result(name, v.c, v.ovf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    for (int v = 0; v < 5; v++) vecs[v] = '0;
    for (int k = 0; k < N*M; k++) begin
      vecs[0].a[k] = 16'(k + 1);
      vecs[0].b[k] = 16'd10;
      vecs[0].c[k] = 16'(k + 11);
      vecs[2].a[k] = 16'd5;
      vecs[2].b[k] = 16'd7;
      vecs[2].c[k] = 16'hFFFE;
      vecs[4].a[k] = 16'hFFFD;
      vecs[4].b[k] = 16'h8000;
      vecs[4].c[k] = E5;
    end
    vecs[2].mode = 1'b1;
    vecs[4].ovf  = 1'b1;
    vecs[1].a[0] = 16'h7FFF; vecs[1].b[0] = 16'd1; vecs[1].c[0] = E3; vecs[1].ovf = 1'b1;
    vecs[3].a[0] = 16'h8000; vecs[3].b[0] = 16'd1; vecs[3].c[0] = E4; vecs[3].ovf = 1'b1;
    vecs[3].mode = 1'b1;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive('0, '0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset handshake", 96'({in_ready, out_valid, in_ready3, out_valid3}), 96'(4'b1010));
    check("reset c", 96'({c_flat, overflow}), 96'(0));
    check("reset c rpc3", 96'({c3_flat, overflow3}), 96'(0));

    for (int v = 0; v < 5; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

    // Hold in DONE with back-pressure while inputs keep changing.
    @(negedge clk);
    drive(vecs[0].a, vecs[0].b, vecs[0].mode);
    in_valid = 1'b1;
    @(negedge clk);
    seen = 0;
    while (!out_valid && seen < 20) begin
      drive(mat_t'({$urandom, $urandom, $urandom}), mat_t'({$urandom, $urandom, $urandom}),
            1'($urandom));
      @(negedge clk);
      seen++;
    end
    for (int t = 0; t < 5; t++) begin
      drive(mat_t'({$urandom, $urandom, $urandom}), mat_t'({$urandom, $urandom, $urandom}),
            1'($urandom));
      @(negedge clk);
      check($sformatf("hold c t%0d", t), 96'(c_flat), 96'(vecs[0].c));
      check($sformatf("hold flags t%0d", t), 96'({in_ready, out_valid, overflow}), 96'(3'b010));
    end
    drive(vecs[2].a, vecs[2].b, vecs[2].mode);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bubble idle", 96'({in_ready, out_valid}), 96'(2'b10));
    @(negedge clk);
    in_valid = 1'b0;
    check("accept after bubble", 96'(in_ready), 96'(0));
    wait_result("post-hold", vecs[2].c, 1'b0);

    // Reset in the second RUN cycle discards the matrix.
    @(negedge clk);
    drive(vecs[1].a, vecs[1].b, vecs[1].mode);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun rst handshake", 96'({in_ready, out_valid, in_ready3, out_valid3}),
          96'(4'b1010));
    check("midrun rst c", 96'({c_flat, overflow}), 96'(0));
    check("midrun rst c rpc3", 96'({c3_flat, overflow3}), 96'(0));
    seen = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (out_valid || out_valid3) seen++;
    end
    check("no out_valid after rst", 96'(seen), 96'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
